pe_packet_decoder: RTL and testbench

PE_PACKET_DECODER -- requirements
Module: pe_packet_decoder

---
 rtl/pe_packet_decoder.sv | 156 +++++++++++++++
 tb/tb_pe_packet_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_packet_decoder.sv
// pe_packet_decoder: classifies NoC packets from the PE array as output or
// ack packets. Output packets are buffered as records in a small FIFO. Acks
// are tracked per PE so that ts_done pulses once every PE has acked.
module pe_packet_decoder #(
    parameter int FILTER_WIDTH = 8,
    parameter int OUTPUT_WIDTH = 13,
    parameter int NUM_PE       = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int PW          = 5*FILTER_WIDTH + 13,
    localparam int CLW         = PW - 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pkt_in_valid,
    output logic                    pkt_in_ready,
    input  logic [PW-1:0]           pkt_in_data,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [CLW-1:0]          rec_conv_loc,
    output logic [OUTPUT_WIDTH-1:0] rec_residue,
    output logic [3:0]              rec_pe,
    output logic                    rec_spike,
    output logic                    rec_timestep,
    output logic                    ts_done,
    output logic [15:0]             spike_count,
    output logic                    proto_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [CLW-1:0]          conv_loc;
        logic [OUTPUT_WIDTH-1:0] residue;
        logic [3:0]              pe;
        logic                    spike;
        logic                    ts;
    } rec_t;

    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_e;

    rec_t              mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              rdy_q;
    logic [15:0]       expect_q, expect_d;
    logic [NUM_PE-1:0] mask_q, mask_d;
    state_e            state_q, state_d;
    logic [15:0]       spike_q, spike_d;
    logic              err_q, err_d;

    rec_t              in_rec, head;
    logic [3:0]        ack_pe;
    logic              is_ack, accept, push, ack_acc, pop;
    logic              unused_routing;

    // Output-packet field view; the ack view only needs the PE field at [12:9].
    assign in_rec         = {pkt_in_data[PW-1:27], pkt_in_data[14 +: OUTPUT_WIDTH], pkt_in_data[13:8]};
    assign ack_pe         = pkt_in_data[12:9];
    assign unused_routing = ^pkt_in_data[7:0];

    // A packet only counts as an ack when that PE is actually owed one;
    // otherwise an ack-shaped packet is decoded as an ordinary output.
    assign is_ack  = (pkt_in_data[PW-1:13] == '0) && pkt_in_data[8] && expect_q[ack_pe];
    assign accept  = pkt_in_valid && pkt_in_ready;
    assign push    = accept && !is_ack;
    assign ack_acc = accept && is_ack;

    // rdy_q holds ready low through reset and the first edge after release.
    assign pkt_in_ready = rdy_q && (cnt_q != DEPTH_C);
    assign rec_valid    = (cnt_q != '0);
    assign pop          = rec_ready && rec_valid;

    // Head fields read as zero whenever the FIFO is empty.
    assign head         = rec_valid ? mem_q[rd_q] : '0;
    assign rec_conv_loc = head.conv_loc;
    assign rec_residue  = head.residue;
    assign rec_pe       = head.pe;
    assign rec_spike    = head.spike;
    assign rec_timestep = head.ts;
    assign spike_count  = spike_q;
    assign proto_err    = err_q;

    // Record storage; contents are qualified by cnt_q so they need no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_rec;
    end

    // FIFO occupancy: simultaneous push and pop cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Per-PE expect_ack bits, protocol error flag and spike counter.
    always_comb begin
        expect_d = expect_q;
        err_d    = err_q;
        spike_d  = spike_q;
        if (push) begin
            if (in_rec.ts) begin
                if (expect_q[in_rec.pe]) err_d = 1'b1;
                expect_d[in_rec.pe] = 1'b1;
            end
            if ({1'b0, in_rec.pe} >= 5'(NUM_PE)) err_d = 1'b1;
            if (in_rec.spike) spike_d = spike_q + 16'd1;
        end
        if (ack_acc) expect_d[ack_pe] = 1'b0;
    end

    // Ack tracker: COLLECT until every PE has acked, then one DONE cycle that
    // pulses ts_done and clears the mask. An ack landing in DONE is ORed in
    // after the clear so it counts toward the next timestep.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ts_done = 1'b0;
        case (state_q)
            COLLECT: if (&mask_q) state_d = DONE;
            DONE: begin
                ts_done = 1'b1;
                mask_d  = '0;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        for (int i = 0; i < NUM_PE; i++) begin
            if (ack_acc && (ack_pe == 4'(i))) mask_d[i] = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            expect_q <= '0;
            mask_q   <= '0;
            state_q  <= COLLECT;
            spike_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q    <= cnt_d;
            rdy_q    <= 1'b1;
            expect_q <= expect_d;
            mask_q   <= mask_d;
            state_q  <= state_d;
            spike_q  <= spike_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_pe_packet_decoder.sv
// Self-checking bench for pe_packet_decoder (default parameters).
module tb_pe_packet_decoder;
    localparam int PW = 53;

    typedef struct packed {
        logic [25:0] conv;
        logic [12:0] res;
        logic [3:0]  pe;
        logic        sp;
        logic        ts;
    } rec_t;

    typedef struct {
        bit          use_raw;
        logic [52:0] raw;
        bit          is_rec;
        rec_t        r;
        logic [15:0] exp_sc;
        logic        exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pkt_in_valid = 1'b0;
    logic          pkt_in_ready;
    logic [PW-1:0] pkt_in_data = '0;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [25:0]   rec_conv_loc;
    logic [12:0]   rec_residue;
    logic [3:0]    rec_pe;
    logic          rec_spike, rec_timestep, ts_done, proto_err;
    logic [15:0]   spike_count;

    int   n_checks = 0;
    int   n_fail = 0;
    int   ts_pulses = 0;
    rec_t sbq[$];
    rec_t mon_r;
    vec_t vt[8];

    always #5 clk = ~clk;

    pe_packet_decoder dut (
        .clk(clk), .reset(reset),
        .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready), .pkt_in_data(pkt_in_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_conv_loc(rec_conv_loc), .rec_residue(rec_residue), .rec_pe(rec_pe),
        .rec_spike(rec_spike), .rec_timestep(rec_timestep),
        .ts_done(ts_done), .spike_count(spike_count), .proto_err(proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [52:0] mk_out(input rec_t r);
        return {r.conv, r.res, r.pe, r.sp, r.ts, 8'hA5};
    endfunction

    function automatic logic [52:0] mk_ack(input logic [3:0] pe);
        return {40'd0, pe, 1'b1, 8'h3C};
    endfunction

    // Scoreboard consumer: every popped head must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (ts_done) ts_pulses++;
            if (rec_valid && rec_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_record: got conv 0x%0h pe %0d, expected no record", rec_conv_loc, rec_pe);
                end else begin
                    mon_r = sbq.pop_front();
                    chk("rec_conv_loc", 32'(rec_conv_loc), 32'(mon_r.conv));
                    chk("rec_residue",  32'(rec_residue),  32'(mon_r.res));
                    chk("rec_pe",       32'(rec_pe),       32'(mon_r.pe));
                    chk("rec_spike",    32'(rec_spike),    32'(mon_r.sp));
                    chk("rec_timestep", 32'(rec_timestep), 32'(mon_r.ts));
                end
            end
        end
    end

    // Offer one packet; expectation is queued at the moment of acceptance.
    task automatic send(input logic [52:0] pkt, input bit is_rec, input rec_t r);
        bit done = 1'b0;
        pkt_in_data  = pkt;
        pkt_in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (pkt_in_ready) begin
                done = 1'b1;
                if (is_rec) sbq.push_back(r);
            end
            @(posedge clk); #1;
        end
        pkt_in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no ready in 20 cycles, expected acceptance");
        end
    endtask

    task automatic send_out(input logic [25:0] c, input logic [12:0] rs, input logic [3:0] p,
                            input logic s, input logic t);
        rec_t r;
        r = '{c, rs, p, s, t};
        send(mk_out(r), 1'b1, r);
    endtask

    task automatic send_ack(input logic [3:0] p);
        send(mk_ack(p), 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pkt_in_valid = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
        chk("rst_rec_valid", 32'(rec_valid), 0);
        chk("rst_ready",     32'(pkt_in_ready), 0);
        chk("rst_ts_done",   32'(ts_done), 0);
        chk("rst_spike",     32'(spike_count), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(negedge clk);
        reset = 1'b0;
        ts_pulses = 0;
        #1 chk("ready_before_first_edge", 32'(pkt_in_ready), 0);
        @(posedge clk); #1;
        chk("ready_after_first_edge", 32'(pkt_in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: output packets and acks with rec_ready held high.
        vt[0] = '{1'b0, 53'd0, 1'b1, '{26'd5, 13'h1A, 4'd2, 1'b1, 1'b0}, 16'd1, 1'b0};
        vt[1] = '{1'b0, 53'd0, 1'b1, '{26'h3FFFFFF, 13'h1FFF, 4'd1, 1'b0, 1'b0}, 16'd1, 1'b0};
        vt[2] = '{1'b0, 53'd0, 1'b1, '{26'd0, 13'd0, 4'd0, 1'b1, 1'b0}, 16'd2, 1'b0};
        vt[3] = '{1'b0, 53'd0, 1'b1, '{26'h123, 13'h0AA, 4'd3, 1'b1, 1'b1}, 16'd3, 1'b0};
        vt[4] = '{1'b1, mk_ack(4'd3), 1'b0, '0, 16'd3, 1'b0};
        // Ack-shaped with ack-field PE 1 not owed an ack: decodes as output pe0, spike, ts.
        vt[5] = '{1'b1, 53'h300, 1'b1, '{26'd0, 13'd0, 4'd0, 1'b1, 1'b1}, 16'd4, 1'b0};
        // Now a genuine ack for PE 0 (its expect bit was set by the previous entry).
        vt[6] = '{1'b1, mk_ack(4'd0), 1'b0, '0, 16'd4, 1'b0};
        vt[7] = '{1'b0, 53'd0, 1'b1, '{26'h2AAAAAA, 13'h1555, 4'd7, 1'b0, 1'b0}, 16'd4, 1'b1};

        do_reset();
        rec_ready = 1'b1;
        chk("tv_rec_valid_idle", 32'(rec_valid), 0);
        for (int i = 0; i < 8; i++) begin
            send(vt[i].use_raw ? vt[i].raw : mk_out(vt[i].r), vt[i].is_rec, vt[i].r);
            if (vt[i].is_rec) chk($sformatf("tv%0d_rec_valid_lat1", i), 32'(rec_valid), 1);
            chk($sformatf("tv%0d_spike_count", i), 32'(spike_count), 32'(vt[i].exp_sc));
            chk($sformatf("tv%0d_proto_err", i), 32'(proto_err), 32'(vt[i].exp_err));
        end
        repeat (4) @(posedge clk);
        #1 chk("tv_drained", 32'(sbq.size()), 0);

        // All four PEs: ts=1 output then ack; ts_done pulses once.
        do_reset();
        rec_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_out(26'(p + 1), 13'(p), 4'(p), 1'b0, 1'b1);
            send_ack(4'(p));
        end
        chk("ts_done_not_yet", 32'(ts_done), 0);
        @(posedge clk); #1 chk("ts_done_pulse", 32'(ts_done), 1);
        @(posedge clk); #1 chk("ts_done_cleared", 32'(ts_done), 0);
        repeat (4) @(posedge clk);
        #1 chk("ts_pulses_round1", 32'(ts_pulses), 1);

        // Round 2 ends with PE0 acking during DONE; round 3 relies on that ack.
        for (int p = 0; p < 4; p++) send_out(26'(16 + p), 13'(p), 4'(p), 1'b1, 1'b1);
        for (int p = 0; p < 3; p++) send_ack(4'(p));
        send_out(26'd99, 13'd9, 4'd0, 1'b0, 1'b1);
        send_ack(4'd3);
        @(posedge clk); #1 chk("ts_done_round2", 32'(ts_done), 1);
        send_ack(4'd0);
        for (int p = 1; p < 4; p++) send_out(26'(32 + p), 13'(p), 4'(p), 1'b0, 1'b1);
        for (int p = 1; p < 4; p++) send_ack(4'(p));
        repeat (5) @(posedge clk);
        #1 chk("ts_pulses_round3", 32'(ts_pulses), 3);
        chk("ack_seq_proto_err", 32'(proto_err), 0);
        chk("ack_seq_spikes", 32'(spike_count), 4);
        chk("ack_seq_drained", 32'(sbq.size()), 0);

        // Backpressure: four fill the FIFO, the fifth waits for a pop.
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_out(26'(100 + i), 13'(i), 4'd1, 1'b0, 1'b0);
        chk("bp_full_ready", 32'(pkt_in_ready), 0);
        chk("bp_head_conv", 32'(rec_conv_loc), 100);
        pkt_in_data  = mk_out('{26'd104, 13'd4, 4'd1, 1'b0, 1'b0});
        pkt_in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_fifth_blocked", 32'(pkt_in_ready), 0);
        chk("bp_head_stable", 32'(rec_conv_loc), 100);
        rec_ready = 1'b1;
        @(posedge clk); #1;
        rec_ready = 1'b0;
        chk("bp_ready_after_pop", 32'(pkt_in_ready), 1);
        sbq.push_back('{26'd104, 13'd4, 4'd1, 1'b0, 1'b0});
        @(posedge clk); #1;
        pkt_in_valid = 1'b0;
        chk("bp_full_again", 32'(pkt_in_ready), 0);
        chk("bp_new_head", 32'(rec_conv_loc), 101);
        rec_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("bp_drained", 32'(sbq.size()), 0);
        chk("bp_empty_valid", 32'(rec_valid), 0);
        send_out(26'd7, 13'd7, 4'd2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("bp_after_idle_pop", 32'(sbq.size()), 0);

        // Duplicate ts=1 from PE3 without an ack: sticky proto_err.
        do_reset();
        rec_ready = 1'b1;
        send_out(26'd1, 13'd1, 4'd3, 1'b0, 1'b1);
        chk("dup_err_first", 32'(proto_err), 0);
        send_out(26'd2, 13'd2, 4'd3, 1'b0, 1'b1);
        chk("dup_err_set", 32'(proto_err), 1);
        repeat (5) @(posedge clk);
        #1 chk("dup_err_sticky", 32'(proto_err), 1);

        // Mid-cycle reset with three records buffered and PE0/PE2 acked.
        do_reset();
        rec_ready = 1'b0;
        send_out(26'd11, 13'd1, 4'd0, 1'b1, 1'b1);
        send_out(26'd12, 13'd2, 4'd2, 1'b0, 1'b1);
        send_out(26'd13, 13'd3, 4'd1, 1'b1, 1'b0);
        send_ack(4'd0);
        send_ack(4'd2);
        chk("pre_rst_valid", 32'(rec_valid), 1);
        chk("pre_rst_spikes", 32'(spike_count), 2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rec_valid), 0);
        chk("async_rst_ready", 32'(pkt_in_ready), 0);
        chk("async_rst_conv",  32'(rec_conv_loc), 0);
        chk("async_rst_res",   32'(rec_residue), 0);
        chk("async_rst_pe",    32'({rec_pe, rec_spike, rec_timestep}), 0);
        chk("async_rst_spikes", 32'(spike_count), 0);
        chk("async_rst_err",   32'({proto_err, ts_done}), 0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        ts_pulses = 0;
        rec_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("post_rst_no_record", 32'(rec_valid), 0);
        chk("post_rst_no_ts_done", 32'(ts_pulses), 0);
        // Expect bits were wiped, so an ack-shaped packet from PE0 is an output.
        send(mk_ack(4'd0), 1'b1, '{26'd0, 13'd0, 4'd0, 1'b0, 1'b1});
        repeat (3) @(posedge clk);
        #1 chk("post_rst_ackshape_record", 32'(sbq.size()), 0);
        chk("post_rst_ts_pulses", 32'(ts_pulses), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
